adc_scan_scheduler: RTL and testbench

//  Owns the 2-channel 12-bit SPI ADC (CH0 = accelerator pedal, CH1 = CDS light sensor) and shares it

---
 rtl/adc_scan_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Shares a 2-channel 12-bit SPI ADC between a periodic scan and on-demand requests,
// runs one 17-SCK conversion frame per grant and publishes raw and 8-bit scaled results.
module adc_scan_scheduler #(
   parameter int CLK_DIV     = 25,
   parameter int SCAN_PERIOD = 50000,
   parameter int CS_GAP      = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        en,
   input  logic [1:0]  req,
   output logic        SPI_SCK,
   output logic        SPI_AD,
   output logic        SPI_DIN,
   input  logic        SPI_DOUT,
   output logic [7:0]  adc_accel,
   output logic [7:0]  adc_cds,
   output logic [11:0] raw_data,
   output logic        raw_ch,
   output logic        data_valid,
   output logic        busy
);

   localparam int DIV_W   = $clog2(CLK_DIV);
   localparam int GAP_CYC = CS_GAP * CLK_DIV;
   localparam int GAP_W   = $clog2(GAP_CYC);
   localparam int SCAN_W  = $clog2(SCAN_PERIOD);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_r;
   logic [DIV_W-1:0]  div_cnt_r;
   logic [4:0]        edge_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic [11:0]       shift_r;
   logic              ch_r;
   logic              last_r;
   logic [1:0]        pending_r;
   logic [SCAN_W-1:0] scan_cnt_r;
   logic              tick_s;
   logic              grant_s;
   logic              grant_ch_s;
   logic [1:0]        clr_s;
   logic              div_end_s;

   // Scan tick and half-period terminal count
   always_comb begin
      tick_s    = 1'b0;
      div_end_s = 1'b0;
      if (en && (scan_cnt_r == SCAN_LAST)) begin
         tick_s = 1'b1;
      end else begin
         tick_s = 1'b0;
      end
      if (div_cnt_r == DIV_LAST) begin
         div_end_s = 1'b1;
      end else begin
         div_end_s = 1'b0;
      end
   end

   // Round-robin arbiter: on a tie, the channel not granted last wins
   always_comb begin
      grant_s    = 1'b0;
      grant_ch_s = 1'b0;
      clr_s      = 2'b00;
      if ((state_r == IDLE) && en && (pending_r != 2'b00)) begin
         grant_s = 1'b1;
         case (pending_r)
            2'b01:   grant_ch_s = 1'b0;
            2'b10:   grant_ch_s = 1'b1;
            2'b11:   grant_ch_s = ~last_r;
            default: grant_ch_s = 1'b0;
         endcase
         clr_s = grant_ch_s ? 2'b10 : 2'b01;
      end else begin
         grant_s    = 1'b0;
         grant_ch_s = 1'b0;
         clr_s      = 2'b00;
      end
   end

   // Scan timer: runs only while enabled, wraps on tick
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scan_cnt_r <= '0;
      end else if (en) begin
         if (tick_s) begin
            scan_cnt_r <= '0;
         end else begin
            scan_cnt_r <= scan_cnt_r + {{(SCAN_W-1){1'b0}}, 1'b1};
         end
      end else begin
         scan_cnt_r <= scan_cnt_r;
      end
   end

   // Pending bits: new requests win over the grant clear, so an in-flight channel re-arms
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending_r <= 2'b00;
      end else begin
         pending_r <= (pending_r & ~clr_s) | req | {2{tick_s}};
      end
   end

   // Frame sequencer with registered SPI pins and result outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= IDLE;
         div_cnt_r  <= '0;
         edge_cnt_r <= 5'd0;
         gap_cnt_r  <= '0;
         shift_r    <= 12'd0;
         ch_r       <= 1'b0;
         last_r     <= 1'b1;
         SPI_SCK    <= 1'b0;
         SPI_AD     <= 1'b1;
         SPI_DIN    <= 1'b0;
         adc_accel  <= 8'd0;
         adc_cds    <= 8'd0;
         raw_data   <= 12'd0;
         raw_ch     <= 1'b0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  state_r    <= SETUP;
                  ch_r       <= grant_ch_s;
                  last_r     <= grant_ch_s;
                  busy       <= 1'b1;
                  SPI_AD     <= 1'b0;
                  SPI_DIN    <= 1'b1;
                  div_cnt_r  <= '0;
                  edge_cnt_r <= 5'd0;
                  shift_r    <= 12'd0;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               if (div_end_s) begin
                  div_cnt_r  <= '0;
                  SPI_SCK    <= 1'b1;
                  edge_cnt_r <= 5'd1;
                  state_r    <= SHIFT;
               end else begin
                  div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            SHIFT: begin
               if (!div_end_s) begin
                  div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
               end else if (SPI_SCK) begin
                  // Falling edge: present the bit the ADC samples on the next rising edge
                  div_cnt_r <= '0;
                  SPI_SCK   <= 1'b0;
                  case (edge_cnt_r)
                     5'd1:    SPI_DIN <= 1'b1;
                     5'd2:    SPI_DIN <= ch_r;
                     5'd3:    SPI_DIN <= 1'b1;
                     default: SPI_DIN <= 1'b0;
                  endcase
               end else if (edge_cnt_r == 5'd17) begin
                  div_cnt_r <= '0;
                  gap_cnt_r <= '0;
                  SPI_AD    <= 1'b1;
                  SPI_DIN   <= 1'b0;
                  state_r   <= HOLD;
               end else begin
                  div_cnt_r  <= '0;
                  SPI_SCK    <= 1'b1;
                  edge_cnt_r <= edge_cnt_r + 5'd1;
                  if (edge_cnt_r >= 5'd5) begin
                     shift_r <= {shift_r[10:0], SPI_DOUT};
                  end else begin
                     shift_r <= shift_r;
                  end
               end
            end
            HOLD: begin
               if (gap_cnt_r == '0) begin
                  raw_data   <= shift_r;
                  raw_ch     <= ch_r;
                  data_valid <= 1'b1;
                  busy       <= 1'b0;
                  if (ch_r) begin
                     adc_cds <= shift_r[11:4];
                  end else begin
                     adc_accel <= shift_r[11:4];
                  end
               end else begin
                  busy <= 1'b0;
               end
               if (gap_cnt_r == GAP_LAST) begin
                  state_r <= IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= IDLE;
               SPI_AD  <= 1'b1;
               SPI_SCK <= 1'b0;
               SPI_DIN <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed self-checking bench for adc_scan_scheduler with a behavioural SPI ADC model.
module tb_adc_scan_scheduler;

   localparam int CLK_DIV     = 4;
   localparam int SCAN_PERIOD = 2000;
   localparam int CS_GAP      = 4;
   localparam int DV_LAT      = 35 * CLK_DIV + 1;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  req = 2'b00;
   logic        SPI_SCK, SPI_AD, SPI_DIN;
   logic        SPI_DOUT = 1'b0;
   logic [7:0]  adc_accel, adc_cds;
   logic [11:0] raw_data;
   logic        raw_ch, data_valid, busy;

   int n_checks = 0;
   int n_fail   = 0;

   adc_scan_scheduler #(.CLK_DIV(CLK_DIV), .SCAN_PERIOD(SCAN_PERIOD), .CS_GAP(CS_GAP)) dut (
      .CLK(CLK), .RST_N(RST_N), .en(en), .req(req),
      .SPI_SCK(SPI_SCK), .SPI_AD(SPI_AD), .SPI_DIN(SPI_DIN), .SPI_DOUT(SPI_DOUT),
      .adc_accel(adc_accel), .adc_cds(adc_cds), .raw_data(raw_data), .raw_ch(raw_ch),
      .data_valid(data_valid), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // ADC model and frame observers
   logic [11:0] val0 = 12'd0, val1 = 12'd0, cur;
   logic [3:0]  cmd = 4'd0;
   int rise_cnt = 0, fall_cnt = 0, ad_falls = 0, dv_cnt = 0;
   int cyc = 0, t_fall = 0, t_rise = 0, dv_gap = 0, min_gap = 99999;

   always @(posedge CLK) cyc++;

   always @(negedge SPI_AD) begin
      ad_falls++;
      rise_cnt = 0;
      fall_cnt = 0;
      cmd = 4'd0;
      if (cyc - t_rise < min_gap) min_gap = cyc - t_rise;
      t_fall = cyc;
   end

   always @(posedge SPI_AD) t_rise = cyc;

   always @(posedge SPI_SCK) begin
      if (!SPI_AD) begin
         rise_cnt++;
         if (rise_cnt <= 4) cmd = {cmd[2:0], SPI_DIN};
      end
   end

   always @(negedge SPI_SCK) begin
      if (!SPI_AD) begin
         fall_cnt++;
         cur = cmd[1] ? val1 : val0;
         if (fall_cnt >= 5 && fall_cnt <= 16) SPI_DOUT = cur[16 - fall_cnt];
         else SPI_DOUT = 1'b0;
      end
   end

   always @(posedge data_valid) begin
      dv_cnt++;
      dv_gap = cyc - t_fall;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic pulse_req(input logic [1:0] v);
      req = v;
      @(negedge CLK);
      req = 2'b00;
   endtask

   task automatic wait_dv(input string tag, input int budget);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge CLK);
         if (data_valid) got = 1'b1;
      end
      check_val({tag, "_dv_seen"}, {31'd0, got}, 32'd1);
   endtask

   task automatic wait_rise(input string tag, input int n, input int budget);
      bit got;
      got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge CLK);
         if (!SPI_AD && rise_cnt >= n) got = 1'b1;
      end
      check_val({tag, "_edge_seen"}, {31'd0, got}, 32'd1);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   int falls0, dv0;

   initial begin
      // 1: reset values, en=0 keeps the bus quiet
      repeat (3) @(negedge CLK);
      check_val("rst_ad", SPI_AD, 1);
      check_val("rst_sck", SPI_SCK, 0);
      check_val("rst_accel", adc_accel, 0);
      check_val("rst_cds", adc_cds, 0);
      check_val("rst_busy", busy, 0);
      RST_N = 1'b1;
      repeat (3 * SCAN_PERIOD) @(negedge CLK);
      check_val("en0_no_frame", ad_falls, 0);

      // 2: single CH0 conversion
      do_reset();
      en = 1'b1;
      val0 = 12'd1000;
      pulse_req(2'b01);
      wait_dv("single", 400);
      check_val("single_raw", raw_data, 1000);
      check_val("single_ch", raw_ch, 0);
      check_val("single_accel", adc_accel, 62);
      check_val("single_cds", adc_cds, 0);
      check_val("single_busy", busy, 0);
      check_val("single_cmd", cmd, 4'b1101);
      check_val("single_edges", rise_cnt, 17);
      check_val("single_latency", dv_gap, DV_LAT);

      // 4: tie break and fairness
      do_reset();
      falls0 = ad_falls;
      val1 = 12'd2000;
      pulse_req(2'b11);
      wait_dv("tie1a", 400);
      check_val("tie1a_ch", raw_ch, 0);
      wait_dv("tie1b", 400);
      check_val("tie1b_ch", raw_ch, 1);
      check_val("tie1b_cmd", cmd, 4'b1111);
      check_val("tie1b_cds", adc_cds, 125);
      pulse_req(2'b11);
      wait_dv("tie2a", 400);
      check_val("tie2a_ch", raw_ch, 0);
      wait_dv("tie2b", 400);
      check_val("tie2b_ch", raw_ch, 1);
      pulse_req(2'b01);
      wait_rise("midreq", 3, 200);
      pulse_req(2'b10);
      wait_dv("rr_a", 400);
      check_val("rr_a_ch", raw_ch, 0);
      wait_dv("rr_b", 400);
      check_val("rr_b_ch", raw_ch, 1);
      repeat (300) @(negedge CLK);
      check_val("rr_frames", ad_falls - falls0, 6);

      // 3: periodic scan rotation
      do_reset();
      val0 = 12'd4000;
      val1 = 12'd2000;
      min_gap = 99999;
      for (int t = 0; t < 2; t++) begin
         wait_dv("scan_ch0", SCAN_PERIOD + 500);
         check_val("scan_ch0_ch", raw_ch, 0);
         check_val("scan_accel", adc_accel, 250);
         check_val("scan_latency", dv_gap, DV_LAT);
         wait_dv("scan_ch1", 400);
         check_val("scan_ch1_ch", raw_ch, 1);
         check_val("scan_cds", adc_cds, 125);
      end
      check_val("scan_cs_gap", {31'd0, (min_gap >= CS_GAP * CLK_DIV)}, 32'd1);

      // 5: full-scale and zero, then en dropped mid-frame
      do_reset();
      val0 = 12'd4095;
      pulse_req(2'b01);
      wait_dv("max", 400);
      check_val("max_accel", adc_accel, 255);
      val0 = 12'd0;
      pulse_req(2'b01);
      wait_dv("zero", 400);
      check_val("zero_accel", adc_accel, 0);
      val0 = 12'd300;
      pulse_req(2'b01);
      wait_rise("endrop", 8, 200);
      en = 1'b0;
      pulse_req(2'b10);
      wait_dv("endrop", 400);
      check_val("endrop_raw", raw_data, 300);
      check_val("endrop_accel", adc_accel, 18);
      falls0 = ad_falls;
      repeat (200) @(negedge CLK);
      check_val("endrop_no_grant", ad_falls, falls0);
      en = 1'b1;
      wait_dv("kept", 400);
      check_val("kept_ch", raw_ch, 1);

      // 6: asynchronous reset mid-frame
      do_reset();
      pulse_req(2'b01);
      wait_rise("arst", 10, 200);
      RST_N = 1'b0;
      #1;
      check_val("arst_ad", SPI_AD, 1);
      check_val("arst_sck", SPI_SCK, 0);
      check_val("arst_busy", busy, 0);
      dv0 = dv_cnt;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      check_val("arst_no_dv", dv_cnt, dv0);
      val0 = 12'd1234;
      pulse_req(2'b01);
      wait_dv("post", 400);
      check_val("post_raw", raw_data, 1234);
      check_val("post_accel", adc_accel, 77);
      check_val("post_edges", rise_cnt, 17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
